// File: rtl/lifo_arbiter_pkg.sv
// Shared types and constants for the LIFO arbiter: FSM state encoding,
// stack operation codes and error-counter sizing.
package lifo_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic OP_POP  = 1'b0;
  localparam logic OP_PUSH = 1'b1;

  localparam int              ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/lifo_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or above
// rr_ptr, wrapping at NREQ. Reusable for any shared-resource controller.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] gnt_onehot,
  output logic [IDW-1:0]  gnt_id,
  output logic            any_req
);

  logic           found;
  logic [IDW-1:0] idx;

  always_comb begin
    gnt_onehot = '0;
    gnt_id     = '0;
    found      = 1'b0;
    idx        = '0;
    any_req    = |req;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((int'(rr_ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        found           = 1'b1;
        gnt_id          = idx;
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lifo_arbiter.sv
// Round-robin front end for a shared LIFO stack: one guarded push or pop per
// three-cycle transaction, with a tagged response to the winning requester.
module lifo_arbiter
  import lifo_arbiter_pkg::*;
#(
  parameter int WL    = 8,
  parameter int DEPTH = 16,
  parameter int NREQ  = 4,
  localparam int IDW  = $clog2(NREQ),
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_op,
  input  logic [NREQ*WL-1:0]   req_data,
  output logic [NREQ-1:0]      req_ack,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [WL-1:0]        rsp_data,
  output logic                 rsp_err,
  output logic [LW-1:0]        level,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 stk_rReq,
  output logic                 stk_wReq,
  output logic [WL-1:0]        stk_din,
  input  logic [WL-1:0]        stk_dout,
  input  logic                 stk_full,
  input  logic                 stk_empty
);

  state_t          state, state_next;
  logic [IDW-1:0]  rr_ptr, gnt_id, arb_id;
  logic [NREQ-1:0] arb_onehot;
  logic            any_req;
  logic            gnt_op;
  logic [WL-1:0]   gnt_data;
  logic            err_pend;
  logic            issue_ok;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req        (req_valid),
    .rr_ptr     (rr_ptr),
    .gnt_onehot (arb_onehot),
    .gnt_id     (arb_id),
    .any_req    (any_req)
  );

  // Guard checked against the live stack flags during ISSUE
  assign issue_ok = (gnt_op == OP_PUSH) ? !stk_full : !stk_empty;

  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ISSUE;
      ISSUE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant latch, shadow level, error bookkeeping and round-robin pointer
  always_ff @(posedge CLK) begin
    if (!RST) begin
      rr_ptr   <= '0;
      gnt_id   <= '0;
      gnt_op   <= OP_POP;
      gnt_data <= '0;
      level    <= '0;
      err_cnt  <= '0;
      err_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_id   <= arb_id;
            gnt_op   <= |(req_op & arb_onehot);
            gnt_data <= req_data[arb_id*WL +: WL];
          end
        end
        ISSUE: begin
          if (issue_ok) begin
            if (gnt_op == OP_PUSH) level <= level + LW'(1);
            else                   level <= level - LW'(1);
          end else begin
            err_pend <= 1'b1;
            if (err_cnt != ERR_CNT_MAX) err_cnt <= err_cnt + ERR_CNT_W'(1);
          end
        end
        RESP: begin
          rr_ptr   <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
          err_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ack   = '0;
    rsp_valid = 1'b0;
    rsp_id    = '0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    stk_rReq  = 1'b0;
    stk_wReq  = 1'b0;
    stk_din   = '0;
    case (state)
      ISSUE: begin
        if (issue_ok && gnt_op == OP_PUSH) begin
          stk_wReq = 1'b1;
          stk_din  = gnt_data;
        end
        if (issue_ok && gnt_op == OP_POP) stk_rReq = 1'b1;
      end
      RESP: begin
        rsp_valid       = 1'b1;
        req_ack[gnt_id] = 1'b1;
        rsp_id          = gnt_id;
        rsp_err         = err_pend;
        if (gnt_op == OP_POP && !err_pend) rsp_data = stk_dout;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lifo_arbiter.sv
// Directed bench for lifo_arbiter with a behavioural LIFO stack attached to
// the stack ports; each scenario task carries its own hand-computed checks.
module tb_lifo_arbiter;

  localparam int WL    = 8;
  localparam int DEPTH = 16;
  localparam int NREQ  = 4;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NREQ-1:0]   req_valid, req_op, req_ack;
  logic [NREQ*WL-1:0] req_data;
  logic              rsp_valid, rsp_err;
  logic [1:0]        rsp_id;
  logic [WL-1:0]     rsp_data, stk_din, stk_dout;
  logic [4:0]        level;
  logic [7:0]        err_cnt;
  logic              stk_rReq, stk_wReq, stk_full, stk_empty;

  int checks = 0;
  int errors = 0;

  logic [WL-1:0] mem [DEPTH];
  logic [4:0]    sp;

  // Behavioural stack: pop data registered on the pop edge
  always @(posedge CLK) begin
    if (!RST) begin
      sp       <= '0;
      stk_dout <= '0;
    end else if (stk_wReq) begin
      mem[sp[3:0]] <= stk_din;
      sp           <= sp + 5'd1;
    end else if (stk_rReq) begin
      stk_dout <= mem[4'(sp - 5'd1)];
      sp       <= sp - 5'd1;
    end
  end
  assign stk_full  = (sp == 5'(DEPTH));
  assign stk_empty = (sp == 5'd0);

  always #5 CLK = ~CLK;

  lifo_arbiter #(.WL(WL), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_op(req_op),
    .req_data(req_data), .req_ack(req_ack), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err), .level(level),
    .err_cnt(err_cnt), .stk_rReq(stk_rReq), .stk_wReq(stk_wReq),
    .stk_din(stk_din), .stk_dout(stk_dout), .stk_full(stk_full),
    .stk_empty(stk_empty)
  );

  logic          got_rsp, saw_w, saw_r;
  int            lat;
  logic [1:0]    c_id;
  logic [WL-1:0] c_data;
  logic          c_err;
  logic [3:0]    c_ack;
  logic [4:0]    c_level;
  logic [7:0]    c_errcnt;

  task automatic apply_reset();
    @(negedge CLK);
    RST = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
  endtask

  // One transaction from requester id; lat counts the request cycle as 1
  task automatic do_txn(input int id, input logic op, input logic [WL-1:0] d);
    @(negedge CLK);
    req_valid[id] = 1'b1;
    req_op[id] = op;
    req_data[id*WL +: WL] = d;
    got_rsp = 0; saw_w = 0; saw_r = 0; lat = 1;
    for (int i = 0; i < 8 && !got_rsp; i++) begin
      @(negedge CLK);
      lat++;
      saw_w |= stk_wReq;
      saw_r |= stk_rReq;
      if (rsp_valid) begin
        got_rsp = 1; c_id = rsp_id; c_data = rsp_data; c_err = rsp_err;
        c_ack = req_ack; c_level = level; c_errcnt = err_cnt;
      end
    end
    req_valid[id] = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    req_valid = 4'hF;
    req_op = 4'hF;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    repeat (2) @(negedge CLK);
    checks++; if ({rsp_valid, req_ack, rsp_id, rsp_data, rsp_err} !== '0) begin errors++; $display("[TB] FAIL reset_rsp: got %b, want 0", {rsp_valid, req_ack, rsp_id, rsp_data, rsp_err}); end
    checks++; if ({level, err_cnt} !== '0) begin errors++; $display("[TB] FAIL reset_cnt: level %0d err_cnt %0d, want 0 0", level, err_cnt); end
    checks++; if ({stk_rReq, stk_wReq, stk_din} !== '0) begin errors++; $display("[TB] FAIL reset_stk: got %b, want 0", {stk_rReq, stk_wReq, stk_din}); end
    RST = 1'b1;
    @(negedge CLK);
    checks++; if (stk_wReq !== 1'b1 || stk_din !== 8'h10) begin errors++; $display("[TB] FAIL reset_first_issue: wReq %b din %h, want 1 10", stk_wReq, stk_din); end
    @(negedge CLK);
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || req_ack !== 4'b0001) begin errors++; $display("[TB] FAIL reset_first_grant: valid %b id %0d ack %b, want 1 0 0001", rsp_valid, rsp_id, req_ack); end
    req_valid = '0;
  endtask

  task automatic test_single();
    apply_reset();
    do_txn(1, 1'b1, 8'hA5);
    checks++; if (got_rsp !== 1'b1 || lat !== 3) begin errors++; $display("[TB] FAIL push_latency: got_rsp %b cycle %0d, want 1 3", got_rsp, lat); end
    checks++; if (c_err !== 1'b0 || c_id !== 2'd1 || c_ack !== 4'b0010 || c_data !== 8'h00) begin errors++; $display("[TB] FAIL push_rsp: err %b id %0d ack %b data %h, want 0 1 0010 00", c_err, c_id, c_ack, c_data); end
    checks++; if (c_level !== 5'd1 || saw_w !== 1'b1) begin errors++; $display("[TB] FAIL push_level: level %0d wreq %b, want 1 1", c_level, saw_w); end
    do_txn(1, 1'b0, 8'h00);
    checks++; if (got_rsp !== 1'b1 || c_data !== 8'hA5 || c_id !== 2'd1 || c_err !== 1'b0) begin errors++; $display("[TB] FAIL pop_rsp: rsp %b data %h id %0d err %b, want 1 a5 1 0", got_rsp, c_data, c_id, c_err); end
    checks++; if (c_level !== 5'd0 || saw_r !== 1'b1) begin errors++; $display("[TB] FAIL pop_level: level %0d rreq %b, want 0 1", c_level, saw_r); end
  endtask

  task automatic test_round_robin();
    int waited;
    apply_reset();
    @(negedge CLK);
    req_valid = 4'hF;
    req_op = 4'hF;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int k = 0; k < 5; k++) begin
      waited = 0;
      do begin @(negedge CLK); waited++; end while (!rsp_valid && waited < 8);
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4) || level !== 5'(k + 1)) begin errors++; $display("[TB] FAIL rr_grant%0d: valid %b id %0d level %0d, want 1 %0d %0d", k, rsp_valid, rsp_id, level, k % 4, k + 1); end
      checks++; if (waited !== ((k == 0) ? 2 : 3)) begin errors++; $display("[TB] FAIL rr_spacing%0d: %0d cycles, want %0d", k, waited, (k == 0) ? 2 : 3); end
    end
    req_valid = '0;
    checks++; if (sp !== 5'd5 || mem[4] !== 8'h10 || mem[3] !== 8'h13) begin errors++; $display("[TB] FAIL rr_stack: sp %0d top %h below %h, want 5 10 13", sp, mem[4], mem[3]); end
  endtask

  task automatic test_boundaries();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      do_txn(0, 1'b1, 8'(8'h80 + i));
      checks++; if (got_rsp !== 1'b1 || c_err !== 1'b0 || c_level !== 5'(i + 1)) begin errors++; $display("[TB] FAIL fill%0d: rsp %b err %b level %0d, want 1 0 %0d", i, got_rsp, c_err, c_level, i + 1); end
    end
    do_txn(0, 1'b1, 8'hEE);
    checks++; if (c_err !== 1'b1 || saw_w !== 1'b0 || c_level !== 5'd16 || c_errcnt !== 8'd1) begin errors++; $display("[TB] FAIL push_full: err %b wreq %b level %0d err_cnt %0d, want 1 0 16 1", c_err, saw_w, c_level, c_errcnt); end
    for (int i = 0; i < DEPTH; i++) begin
      do_txn(0, 1'b0, 8'h00);
      checks++; if (got_rsp !== 1'b1 || c_err !== 1'b0 || c_data !== 8'(8'h8F - i)) begin errors++; $display("[TB] FAIL drain%0d: rsp %b err %b data %h, want 1 0 %h", i, got_rsp, c_err, c_data, 8'(8'h8F - i)); end
    end
    do_txn(0, 1'b0, 8'h00);
    checks++; if (c_err !== 1'b1 || c_data !== 8'h00 || c_errcnt !== 8'd2 || saw_r !== 1'b0 || c_level !== 5'd0) begin errors++; $display("[TB] FAIL pop_empty: err %b data %h err_cnt %0d rreq %b level %0d, want 1 00 2 0 0", c_err, c_data, c_errcnt, saw_r, c_level); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    apply_reset();
    do_txn(0, 1'b1, 8'h55);
    @(negedge CLK);
    req_valid[2] = 1'b1;
    req_op[2] = 1'b0;
    @(negedge CLK);
    checks++; if (stk_rReq !== 1'b1) begin errors++; $display("[TB] FAIL mid_issue: rreq %b, want 1", stk_rReq); end
    RST = 1'b0;
    req_valid = '0;
    seen = 1'b0;
    @(negedge CLK);
    seen |= rsp_valid;
    RST = 1'b1;
    repeat (3) begin @(negedge CLK); seen |= rsp_valid; end
    checks++; if (seen !== 1'b0 || level !== 5'd0 || sp !== 5'd0) begin errors++; $display("[TB] FAIL mid_abort: rsp_seen %b level %0d sp %0d, want 0 0 0", seen, level, sp); end
    do_txn(2, 1'b0, 8'h00);
    checks++; if (got_rsp !== 1'b1 || c_err !== 1'b1 || c_id !== 2'd2 || c_errcnt !== 8'd1) begin errors++; $display("[TB] FAIL mid_pop_after: rsp %b err %b id %0d err_cnt %0d, want 1 1 2 1", got_rsp, c_err, c_id, c_errcnt); end
  endtask

  task automatic test_withdrawal();
    int waited;
    apply_reset();
    @(negedge CLK);
    req_valid = 4'b1000;
    req_op[3] = 1'b1;
    req_data[3*WL +: WL] = 8'h3C;
    @(negedge CLK);
    req_valid = '0;
    waited = 0;
    while (!rsp_valid && waited < 8) begin @(negedge CLK); waited++; end
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || req_ack !== 4'b1000) begin errors++; $display("[TB] FAIL withdraw_ack: valid %b id %0d ack %b, want 1 3 1000", rsp_valid, rsp_id, req_ack); end
    checks++; if (rsp_err !== 1'b0 || level !== 5'd1 || mem[0] !== 8'h3C) begin errors++; $display("[TB] FAIL withdraw_push: err %b level %0d mem0 %h, want 0 1 3c", rsp_err, level, mem[0]); end
  endtask

  initial begin
    req_valid = '0;
    req_op = '0;
    req_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_boundaries();
    test_reset_mid();
    test_withdrawal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lifo_arbiter.md
# lifo_arbiter

Round-robin controller that shares one LIFO stack (push/pop strobes, registered pop data, Full/Empty flags) among NREQ requesters. It serialises requests into one stack operation per transaction. Each push or pop is checked against the stack's Full/Empty flags before the strobe is issued. Every transaction returns a tagged response to the winning requester. It sits between the stack instance and its client blocks, and is the only driver of the stack's rReq/wReq/din ports.

## Interface
- WL, 8: data word width; must match the stack instance.
- DEPTH, 16: stack depth; must match the stack instance. Sizes `level` as $clog2(DEPTH+1).
- NREQ, 4: number of requesters, 2..8. IDW = $clog2(NREQ).
- CLK  in  1  single clock; all logic on the rising edge.
- RST  in  1  synchronous, active-low reset. The stack instance shares the same CLK/RST.
- req_valid  in  NREQ  requester i has a pending operation. Held with op/data until its ack.
- req_op  in  NREQ  per requester: 1 = push, 0 = pop.
- req_data  in  NREQ*WL  push data, requester i at bits [i*WL +: WL].
- req_ack  out  NREQ  one-hot, one-cycle pulse in the RESP cycle of the granted requester.
- rsp_valid  out  1  response strobe, coincident with req_ack.
- rsp_id  out  IDW  index of the requester being answered.
- rsp_data  out  WL  popped word. 0 for pushes and errors.
- rsp_err  out  1  operation rejected (push when full, pop when empty).
- level  out  $clog2(DEPTH+1)  shadow occupancy count kept by the controller.
- err_cnt  out  8  saturating count of rejected operations.
- stk_rReq, stk_wReq  out  1  stack pop/push strobes. Never both high.
- stk_din  out  WL  stack write data.
- stk_dout  in  WL  stack read data, registered by the stack on the pop edge.
- stk_full, stk_empty  in  1  stack flags, combinational from the stack pointer.

## Operation
- FSM states: IDLE, ISSUE, RESP. Encoding lives in the package.
- IDLE
  - If any req_valid is high, pick the winner by round-robin, searching upward from rr_ptr with wrap at NREQ.
  - Register gnt_id, gnt_op and gnt_data, then go to ISSUE.
  - If no request is pending, stay in IDLE.
- ISSUE
  - Push with stk_full=0: stk_wReq=1, stk_din=gnt_data, level+1.
  - Pop with stk_empty=0: stk_rReq=1, level-1.
  - Push with stk_full=1, or pop with stk_empty=1: no strobe is issued. Set err_pend=1 and increment err_cnt unless it is at 255.
  - Always go to RESP next.
- RESP
  - rsp_valid=1 and req_ack[gnt_id]=1 for exactly one cycle. rsp_id=gnt_id.
  - rsp_data=stk_dout for a successful pop, otherwise 0. rsp_err=err_pend.
  - rr_ptr <= (gnt_id+1) mod NREQ. Clear err_pend, then go to IDLE.
- Strobes are combinational from the state and the registered grant. They are high only in ISSUE.
- A requester that drops req_valid before its ack is still answered: the grant is latched.
- req_valid asserted during ISSUE or RESP is not sampled until the next IDLE.
- level stays equal to the stack pointer at all times. stk_full = (level==DEPTH) and stk_empty = (level==0) are assertable invariants.

## Timing
- Reset values: state=IDLE, rr_ptr=0, level=0, err_cnt=0, err_pend=0. All outputs 0.
- Throughput: one transaction per 3 cycles.
  - Request sampled in IDLE at edge T.
  - Strobe is high during T..T+1 (ISSUE).
  - Response is high during T+1..T+2 (RESP).
- Pop latency: the stack loads dout at the ISSUE edge, so stk_dout is valid throughout RESP. No extra wait state.
- Back-to-back: a requester holding req_valid after its ack is eligible again in the next IDLE cycle, at lowest priority after its own grant.
- Reset mid-transaction (RST low in ISSUE or RESP):
  - Next edge returns to IDLE with every output cleared.
  - No ack or response is issued for the aborted grant.
  - The stack resets simultaneously, so level=0 stays consistent.
- Full/empty boundary: a push to a stack at DEPTH-1 succeeds and leaves level=DEPTH. The next push is rejected.

## Structure
- Package lifo_arbiter_pkg: state encoding (IDLE/ISSUE/RESP), op encoding constants (OP_POP=0, OP_PUSH=1), err_cnt width and saturation constant.
- Sub-module rr_arbiter (parameter NREQ).
  - Inputs: req vector and rr_ptr.
  - Outputs: gnt_onehot, gnt_id and any_req, all combinational.
  - Reusable for other shared-resource controllers.
- Top level holds the FSM, grant registers, level counter, err_cnt and the stack port drive. The stack itself is instantiated outside, next to this block.

## Test plan
- Reset: RST=0 for 2 cycles with all req_valid high.
  - Expect every output 0 and no stack strobe.
  - After RST=1, the first grant goes to requester 0.
- Single push/pop: requester 1 pushes 0xA5, then pops.
  - Push: ack at cycle 3, rsp_err=0, level=1.
  - Pop: rsp_data=0xA5, rsp_id=1, level=0.
- Round-robin: all 4 requesters hold push requests with data 0x10..0x13.
  - Expect grants 0,1,2,3,0, one every 3 cycles, and level increasing 1..5.
- Boundaries:
  - Fill to DEPTH=16; the 17th push gives rsp_err=1, no stk_wReq, level stays 16, err_cnt=1.
  - Drain 16 pops in LIFO order; the 17th pop gives rsp_err=1, rsp_data=0, err_cnt=2.
- Reset mid-operation: RST=0 during ISSUE of a pop.
  - Expect no rsp_valid for that grant and level=0 after reset.
  - A subsequent pop from requester 2 is rejected with rsp_err=1.
- Valid withdrawal: requester 3 drops req_valid the cycle after it is granted.
  - Expect it is still acked, with rsp_id=3, in RESP.
